// File: rtl/result_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : result_unpacker
// Description : Drain-side companion of the detection result buffer. On a
//               start request it reads the shared result FIFO, whose 12-bit
//               words come in triplets (ori_x, ori_y, candidate). Each triplet
//               is reassembled into one parallel record and presented on a
//               valid/ready handshake toward the LED/HEX display path. Once
//               the FIFO is empty a one-cycle done pulse is issued.
//
// Parameters  : DATA_WIDTH_12 - width of FIFO words, coordinates and counter
//               NUM_RESIZE    - number of resize levels (candidate mask width)
//
// Ports       : clk         - clock, all logic on the rising edge
//               reset       - synchronous, active-high reset
//               start       - one-cycle drain request, sampled only in IDLE
//               fifo_usedw  - words currently held in the result FIFO
//               fifo_q      - FIFO read data, valid one cycle after rdreq
//               fifo_rdreq  - registered FIFO read strobe
//               o_x, o_y    - record coordinates (words 0 and 1)
//               o_candidate - record candidate mask (low bits of word 2)
//               o_valid     - record valid, held until accepted
//               i_ready     - downstream accept
//               o_busy      - high in every state except IDLE
//               o_done      - one-cycle pulse when the FIFO has been drained
//               o_count     - records emitted since the last start
//
// Build macro : RESULT_UNPACKER_FILTER_EN - when defined, records whose
//               candidate mask is zero are discarded instead of emitted.
//
// Revision    : 1.0 - initial release
// ============================================================================

module result_unpacker #(
   parameter int DATA_WIDTH_12 = 12,
   parameter int NUM_RESIZE    = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [DATA_WIDTH_12-1:0] fifo_usedw,
   input  logic [DATA_WIDTH_12-1:0] fifo_q,
   output logic                     fifo_rdreq,
   output logic [DATA_WIDTH_12-1:0] o_x,
   output logic [DATA_WIDTH_12-1:0] o_y,
   output logic [NUM_RESIZE-1:0]    o_candidate,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic                     o_busy,
   output logic                     o_done,
   output logic [DATA_WIDTH_12-1:0] o_count
);

   // A record is only fetched once the whole triplet is present; fewer words
   // mean the writer is still in the middle of a record.
   localparam logic [DATA_WIDTH_12-1:0] c_record_words = DATA_WIDTH_12'(3);
   localparam logic [1:0]               c_last_idx     = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CHECK  = 3'd1,
      ST_FETCH  = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_OUTPUT = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

   state_t                   state_q, state_d;
   logic [1:0]               idx_q, idx_d;
   logic                     rdreq_q, rdreq_d;
   logic [DATA_WIDTH_12-1:0] x_q, x_d;
   logic [DATA_WIDTH_12-1:0] y_q, y_d;
   logic [NUM_RESIZE-1:0]    cand_q, cand_d;
   logic                     valid_q, valid_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic [DATA_WIDTH_12-1:0] count_q, count_d;

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      rdreq_d = 1'b0;
      x_d     = x_q;
      y_d     = y_q;
      cand_d  = cand_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      count_d = count_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_CHECK;
               count_d = '0;
            end
         end

         ST_CHECK: begin
            if (fifo_usedw == '0) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else if (fifo_usedw >= c_record_words) begin
               // The strobe is registered, so it is raised on the same edge
               // that enters FETCH and is high for all three FETCH cycles.
               state_d = ST_FETCH;
               idx_d   = 2'd0;
               rdreq_d = 1'b1;
            end
         end

         ST_FETCH: begin
            // Read data trails the strobe by one cycle: the FETCH cycle with
            // index k sees the word requested at index k-1.
            if (idx_q == 2'd1) begin
               x_d = fifo_q;
            end
            if (idx_q == 2'd2) begin
               y_d = fifo_q;
            end
            if (idx_q == c_last_idx) begin
               state_d = ST_DRAIN;
            end else begin
               idx_d   = idx_q + 2'd1;
               rdreq_d = 1'b1;
            end
         end

         ST_DRAIN: begin
            // Last word of the triplet; only the mask bits are meaningful.
            cand_d = fifo_q[NUM_RESIZE-1:0];
`ifdef RESULT_UNPACKER_FILTER_EN
            if (fifo_q[NUM_RESIZE-1:0] == '0) begin
               state_d = ST_CHECK;
            end else begin
               state_d = ST_OUTPUT;
               valid_d = 1'b1;
            end
`else
            state_d = ST_OUTPUT;
            valid_d = 1'b1;
`endif
         end

         ST_OUTPUT: begin
            if (valid_q && i_ready) begin
               valid_d = 1'b0;
               count_d = count_q + DATA_WIDTH_12'(1);
               state_d = ST_CHECK;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // ------------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         idx_q   <= 2'd0;
         rdreq_q <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         cand_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         rdreq_q <= rdreq_d;
         x_q     <= x_d;
         y_q     <= y_d;
         cand_q  <= cand_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         count_q <= count_d;
      end
   end

   assign fifo_rdreq  = rdreq_q;
   assign o_x         = x_q;
   assign o_y         = y_q;
   assign o_candidate = cand_q;
   assign o_valid     = valid_q;
   assign o_busy      = busy_q;
   assign o_done      = done_q;
   assign o_count     = count_q;

endmodule

`default_nettype wire

// File: tb/tb_result_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_unpacker
// Description : Directed self-checking bench for result_unpacker. A small
//               FIFO model (queue) feeds the DUT; all expected values are
//               hand-computed constants. Inputs change and outputs are
//               observed on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_result_unpacker;

   localparam int DW = 12;
   localparam int NR = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [DW-1:0] fifo_usedw;
   logic [DW-1:0] fifo_q;
   logic          fifo_rdreq;
   logic [DW-1:0] o_x;
   logic [DW-1:0] o_y;
   logic [NR-1:0] o_candidate;
   logic          o_valid;
   logic          i_ready;
   logic          o_busy;
   logic          o_done;
   logic [DW-1:0] o_count;

   logic [DW-1:0] fifo_mem[$];
   logic          usedw_ovr;
   int            rd_count;
   int            n_checks;
   int            n_pass;

   always #5 clk = ~clk;

   result_unpacker #(
      .DATA_WIDTH_12(DW),
      .NUM_RESIZE   (NR)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .fifo_usedw (fifo_usedw),
      .fifo_q     (fifo_q),
      .fifo_rdreq (fifo_rdreq),
      .o_x        (o_x),
      .o_y        (o_y),
      .o_candidate(o_candidate),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_count    (o_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // One clock cycle, entered and left at the falling edge. Models a normal
   // (non show-ahead) FIFO: a strobe seen at the rising edge pops a word.
   task automatic cyc();
      logic rd;
      rd = fifo_rdreq;
      @(posedge clk);
      #1;
      if (rd === 1'b1) begin
         rd_count++;
         if (fifo_mem.size() > 0) fifo_q = fifo_mem.pop_front();
      end
      if (!usedw_ovr) fifo_usedw = DW'(fifo_mem.size());
      @(negedge clk);
   endtask

   task automatic push_rec(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [DW-1:0] w2);
      fifo_mem.push_back(x);
      fifo_mem.push_back(y);
      fifo_mem.push_back(w2);
      if (!usedw_ovr) fifo_usedw = DW'(fifo_mem.size());
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      while (o_valid !== 1'b1 && n < 30) begin
         cyc();
         n++;
      end
      check({tag, "_valid_seen"}, 32'(o_valid === 1'b1), 32'd1);
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (o_done !== 1'b1 && n < 30) begin
         cyc();
         n++;
      end
      check({tag, "_done_seen"}, 32'(o_done === 1'b1), 32'd1);
      cyc();
      check({tag, "_done_one_cycle"}, 32'(o_done), 32'd0);
      check({tag, "_busy_fall"}, 32'(o_busy), 32'd0);
   endtask

   task automatic rec_check(input string tag, input logic [DW-1:0] x, input logic [DW-1:0] y,
                            input logic [NR-1:0] c);
      check({tag, "_x"}, 32'(o_x), 32'(x));
      check({tag, "_y"}, 32'(o_y), 32'(y));
      check({tag, "_cand"}, 32'(o_candidate), 32'(c));
   endtask

   initial begin
      int rd_before;
      n_checks   = 0;
      n_pass     = 0;
      rd_count   = 0;
      reset      = 1'b1;
      start      = 1'b0;
      i_ready    = 1'b0;
      usedw_ovr  = 1'b0;
      fifo_usedw = '0;
      fifo_q     = '0;
      @(negedge clk);
      repeat (3) cyc();

      // ---------------- reset values ----------------
      check("rst_rdreq", 32'(fifo_rdreq), 32'd0);
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_done", 32'(o_done), 32'd0);
      check("rst_count", 32'(o_count), 32'd0);
      check("rst_xyc", {8'd0, o_x, o_y}, 32'd0);
      reset = 1'b0;
      cyc();

      // ---------------- empty FIFO: done at N+2, busy falls N+3 ------------
      pulse_start();                                    // now N+1
      check("empty_busy_n1", 32'(o_busy), 32'd1);
      check("empty_done_n1", 32'(o_done), 32'd0);
      cyc();                                            // N+2
      check("empty_done_n2", 32'(o_done), 32'd1);
      check("empty_busy_n2", 32'(o_busy), 32'd1);
      cyc();                                            // N+3
      check("empty_done_n3", 32'(o_done), 32'd0);
      check("empty_busy_n3", 32'(o_busy), 32'd0);
      check("empty_no_rdreq", 32'(rd_count), 32'd0);
      check("empty_count", 32'(o_count), 32'd0);

      // ---------------- single record, exact timing -----------------------
      i_ready = 1'b1;
      push_rec(12'd100, 12'd200, 12'h004);
      pulse_start();                                    // N+1 CHECK
      check("one_rdreq_n1", 32'(fifo_rdreq), 32'd0);
      cyc();                                            // N+2
      check("one_rdreq_n2", 32'(fifo_rdreq), 32'd1);
      cyc();
      cyc();                                            // N+4
      check("one_rdreq_n4", 32'(fifo_rdreq), 32'd1);
      cyc();                                            // N+5
      check("one_rdreq_n5", 32'(fifo_rdreq), 32'd0);
      check("one_valid_n5", 32'(o_valid), 32'd0);
      cyc();                                            // N+6
      check("one_valid_n6", 32'(o_valid), 32'd1);
      rec_check("one", 12'd100, 12'd200, 5'd4);
      cyc();                                            // accepted at N+6
      check("one_valid_drop", 32'(o_valid), 32'd0);
      check("one_count", 32'(o_count), 32'd1);
      check("one_rd_total", 32'(rd_count), 32'd3);
      wait_done("one");

      // ---------------- three records, stall on the second ----------------
      push_rec(12'd10, 12'd11, 12'h001);
      push_rec(12'd20, 12'd21, 12'h002);
      push_rec(12'hFFF, 12'd0, 12'h01F);
      pulse_start();
      check("three_count_clr", 32'(o_count), 32'd0);
      wait_valid("r1");
      rec_check("r1", 12'd10, 12'd11, 5'd1);
      cyc();
      wait_valid("r2");
      i_ready = 1'b0;
      repeat (5) cyc();
      check("r2_stall_valid_mid", 32'(o_valid), 32'd1);
      rec_check("r2_stall_mid", 12'd20, 12'd21, 5'd2);
      repeat (5) cyc();
      check("r2_stall_valid", 32'(o_valid), 32'd1);
      check("r2_stall_count", 32'(o_count), 32'd1);
      rec_check("r2", 12'd20, 12'd21, 5'd2);
      i_ready = 1'b1;
      cyc();
      check("r2_accept", 32'(o_valid), 32'd0);
      wait_valid("r3");
      rec_check("r3", 12'hFFF, 12'd0, 5'd31);
      cyc();
      check("three_count", 32'(o_count), 32'd3);
      wait_done("three");

      // ---------------- partial record: usedw=2 holds in CHECK ------------
      push_rec(12'd55, 12'd66, 12'h008);
      usedw_ovr  = 1'b1;
      fifo_usedw = 12'd2;
      rd_before  = rd_count;
      pulse_start();
      repeat (20) cyc();
      check("part_no_rdreq", 32'(rd_count - rd_before), 32'd0);
      check("part_busy", 32'(o_busy), 32'd1);
      check("part_no_valid", 32'(o_valid), 32'd0);
      usedw_ovr  = 1'b0;
      fifo_usedw = DW'(fifo_mem.size());
      wait_valid("part");
      rec_check("part", 12'd55, 12'd66, 5'd8);
      cyc();
      check("part_count", 32'(o_count), 32'd1);
      wait_done("part");

      // ---------------- zero-mask record followed by mask 1 ---------------
      // Upper bits of word 2 are set to show they are ignored.
      push_rec(12'd7, 12'd8, 12'hFE0);
      push_rec(12'd9, 12'd10, 12'hFE1);
      pulse_start();
`ifndef RESULT_UNPACKER_FILTER_EN
      wait_valid("z0");
      rec_check("z0", 12'd7, 12'd8, 5'd0);
      cyc();
`endif
      wait_valid("z1");
      rec_check("z1", 12'd9, 12'd10, 5'd1);
      cyc();
`ifdef RESULT_UNPACKER_FILTER_EN
      check("zero_count", 32'(o_count), 32'd1);
`else
      check("zero_count", 32'(o_count), 32'd2);
`endif
      wait_done("zero");

      // ---------------- reset during the second rdreq ---------------------
      push_rec(12'd1, 12'd2, 12'h003);
      pulse_start();                                    // N+1
      cyc();                                            // N+2 first rdreq
      cyc();                                            // N+3 second rdreq
      check("mid_rdreq2", 32'(fifo_rdreq), 32'd1);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      check("mid_rst_rdreq", 32'(fifo_rdreq), 32'd0);
      check("mid_rst_busy", 32'(o_busy), 32'd0);
      check("mid_rst_valid", 32'(o_valid), 32'd0);
      check("mid_rst_done", 32'(o_done), 32'd0);
      check("mid_rst_count", 32'(o_count), 32'd0);
      rd_before = rd_count;
      repeat (8) cyc();
      check("mid_no_rdreq", 32'(rd_count - rd_before), 32'd0);
      check("mid_idle", 32'(o_busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/result_unpacker.md
# result_unpacker

Drain-side companion of the detection result buffer. After a frame, it reads the shared result FIFO (12-bit words, three per detection: ori_x, ori_y, candidate) and reassembles each triplet into one parallel record. Records leave on a valid/ready handshake toward the LED/HEX display path. When the FIFO is empty, a one-cycle done pulse is issued.

## Interface
- DATA_WIDTH_12, 12, width of FIFO words, coordinates and counters
- NUM_RESIZE, 5, number of resize levels; width of candidate bitmask
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high
- start  input  1  one-cycle request to drain the FIFO; sampled only in IDLE
- fifo_usedw  input  DATA_WIDTH_12  words currently held in result FIFO
- fifo_q  input  DATA_WIDTH_12  FIFO read data, valid one cycle after fifo_rdreq
- fifo_rdreq  output  1  FIFO read strobe, registered
- o_x  output  DATA_WIDTH_12  record x (word 0)
- o_y  output  DATA_WIDTH_12  record y (word 1)
- o_candidate  output  NUM_RESIZE  record candidate mask (low NUM_RESIZE bits of word 2)
- o_valid  output  1  record valid; held until accepted
- i_ready  input  1  downstream accepts when o_valid && i_ready
- o_busy  output  1  high in every state except IDLE
- o_done  output  1  one-cycle pulse, FIFO drained
- o_count  output  DATA_WIDTH_12  records emitted since last start

## Operation
- States: IDLE, CHECK, FETCH, DRAIN, OUTPUT, DONE.
- IDLE: start=1 -> CHECK; clear o_count. Otherwise stay.
- CHECK: fifo_usedw==0 -> DONE. fifo_usedw>=3 -> FETCH with word index 0. fifo_usedw of 1 or 2 means a partial record (writer mid-triplet) -> stay in CHECK.
- FETCH: fifo_rdreq=1 for exactly 3 consecutive cycles (word index 0,1,2), then -> DRAIN.
- Capture: fifo_q is registered one cycle after each rdreq into x, y, candidate in order. Upper DATA_WIDTH_12-NUM_RESIZE bits of word 2 are ignored.
- DRAIN: captures word 2 -> OUTPUT.
- OUTPUT: o_valid=1 with stable o_x/o_y/o_candidate. On o_valid&&i_ready: o_count+1 (wraps at 2^DATA_WIDTH_12), o_valid drops next cycle, -> CHECK.
- DONE: o_done=1 for one cycle -> IDLE.
- start outside IDLE is ignored. No fifo_rdreq is ever issued unless fifo_usedw>=3 was seen in CHECK.
- i_ready high before o_valid is legal and gives acceptance on the first OUTPUT cycle.
- Reset mid-operation: next cycle is IDLE, all outputs are 0, and no further rdreq is issued. FIFO content is untouched; a partially read record is lost.

## Timing
- Reset values: fifo_rdreq=0, o_x=0, o_y=0, o_candidate=0, o_valid=0, o_busy=0, o_done=0, o_count=0.
- start in cycle N (IDLE) -> CHECK at N+1. With usedw>=3, rdreq is high N+2..N+4, words arrive N+3..N+5, and o_valid rises at N+6.
- Steady throughput with i_ready held high: one record per 6 cycles (CHECK, 3×FETCH, DRAIN, OUTPUT).
- Empty FIFO at start in N: o_done pulses at N+2, o_busy falls at N+3.
- o_busy is registered from state; o_done and o_valid are registered.

## Configuration
- RESULT_UNPACKER_FILTER_EN defined: a record whose candidate mask is 0 is discarded. OUTPUT is skipped (DRAIN -> CHECK), o_valid is not asserted, and o_count is not incremented.
- Not defined: every record is emitted regardless of mask.

## Test plan
- Reset then start with empty FIFO -> no rdreq; o_done pulse exactly 2 cycles after start; o_count=0.
- FIFO holds (100, 200, 5'b00100), i_ready=1 -> one record x=100 y=200 cand=4; o_valid rises 6 cycles after start; o_count=1; then o_done.
- Three records with i_ready low for 10 cycles on the second -> outputs held stable while stalled; all three emitted in order; o_count=3.
- usedw=2 for 20 cycles, then 3 -> stays in CHECK with no rdreq; resumes and emits correct record once usedw=3.
- Record with cand=0 followed by cand=1 -> without macro both emitted, o_count=2; with RESULT_UNPACKER_FILTER_EN only cand=1 emitted, o_count=1.
- reset asserted during FETCH (second rdreq) -> next cycle all outputs 0 and state IDLE; rdreq stays 0 until the next start.
